// File: rtl/pixel_window_shifter_if.sv
// Pixel window shifter bus: pixel stream in (en, h_sync, data_in), window and status out.
// The master modport is the pixel producer; the slave modport is the shifter.
interface pixel_window_shifter_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned TAPS   = 5
);
  localparam int unsigned CNT_W = $clog2(TAPS + 1);

  logic                     en;
  logic                     h_sync;
  logic [DATA_W-1:0]        data_in;
  logic [DATA_W*TAPS-1:0]   data_out;
  logic                     window_valid;
  logic [CNT_W-1:0]         fill_count;
  logic                     line_start_seen;

  modport master (
    output en,
    output h_sync,
    output data_in,
    input  data_out,
    input  window_valid,
    input  fill_count,
    input  line_start_seen
  );

  modport slave (
    input  en,
    input  h_sync,
    input  data_in,
    output data_out,
    output window_valid,
    output fill_count,
    output line_start_seen
  );
endinterface

// File: rtl/pixel_window_shifter.sv
// Line-aware horizontal pixel-window shift register.
// Newest pixel sits in the top DATA_W bits of data_out, oldest in the bottom bits.
// Optional feature macro: PIXEL_WINDOW_BORDER_REPLICATE_EN -- when defined, the first pixel of
// a line is replicated into every tap and the window is valid immediately; when undefined, the
// other taps are zeroed and valid rises on the TAPS-th pixel of the line.
module pixel_window_shifter #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned TAPS   = 5,
  parameter int unsigned CNT_W  = $clog2(TAPS + 1)
) (
  input logic                  clk,
  input logic                  rst,
  pixel_window_shifter_if.slave bus
);

  localparam int unsigned WIN_W = DATA_W * TAPS;
  localparam logic [CNT_W-1:0] TapsCnt = CNT_W'(TAPS);

  // Fill state is fully encoded by fill_count; the enum just names it.
  typedef enum logic [0:0] {
    StFill,
    StFull
  } state_e;

  logic [WIN_W-1:0] data_q, data_d;
  logic [CNT_W-1:0] fill_count_q, fill_count_d;
  logic             valid_q, valid_d;
  logic             lss_q, lss_d;
  logic             first_pix;
  state_e           state;

  assign state     = (fill_count_q == TapsCnt) ? StFull : StFill;
  // A pending h_sync (armed while idle) or a coincident one makes this pixel start a line.
  assign first_pix = bus.en & (bus.h_sync | lss_q);

  // Next-state: window contents, fill count, valid and line-start arming.
  always_comb begin
    data_d       = data_q;
    fill_count_d = fill_count_q;
    lss_d        = lss_q;

    if (bus.en) begin
      lss_d = 1'b0;
      if (first_pix) begin
`ifdef PIXEL_WINDOW_BORDER_REPLICATE_EN
        data_d       = {TAPS{bus.data_in}};
        fill_count_d = TapsCnt;
`else
        data_d                      = '0;
        data_d[WIN_W-1 -: DATA_W]   = bus.data_in;
        fill_count_d                = CNT_W'(1);
`endif
      end else begin
        data_d = {bus.data_in, data_q[WIN_W-1:DATA_W]};
        unique case (state)
          StFill:  fill_count_d = fill_count_q + CNT_W'(1);
          StFull:  fill_count_d = TapsCnt;
          default: fill_count_d = TapsCnt;
        endcase
      end
    end else if (bus.h_sync) begin
      lss_d = 1'b1;
    end

    valid_d = (fill_count_d == TapsCnt);
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q       <= '0;
      fill_count_q <= '0;
      valid_q      <= 1'b0;
      lss_q        <= 1'b0;
    end else begin
      data_q       <= data_d;
      fill_count_q <= fill_count_d;
      valid_q      <= valid_d;
      lss_q        <= lss_d;
    end
  end

  assign bus.data_out        = data_q;
  assign bus.fill_count      = fill_count_q;
  assign bus.window_valid    = valid_q;
  assign bus.line_start_seen = lss_q;

endmodule

// File: doc/pixel_window_shifter.md
Name: pixel_window_shifter

Overview:
- Parametrised horizontal pixel-window shift register for the image-processing pipeline: DATA_W-bit pixels, TAPS-deep window.
- Adds line awareness (h_sync marks start of line), a fill counter and a window-valid flag.
- Feeds the neighbourhood filters (blur, edge, median) with a full horizontal window per accepted pixel.
- Default configuration (8-bit, 5 taps) produces the same 40-bit packed window as the existing 5-tap pixel shifter.

Parameters:
- DATA_W, 8, pixel width in bits (>=1).
- TAPS, 5, window depth in pixels (>=2).
- CNT_W, $clog2(TAPS+1), width of fill_count (derived; not overridden).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  pixel strobe; data_in is accepted on a rising edge where en=1.
- h_sync  input  1  start-of-line marker, active-high, qualified as described in Behaviour.
- data_in  input  DATA_W  incoming pixel.
- data_out  output  DATA_W*TAPS  packed window.
  - Bits [DATA_W*TAPS-1 -: DATA_W] hold the newest pixel (tap TAPS-1).
  - Bits [DATA_W-1:0] hold the oldest pixel (tap 0).
- window_valid  output  1  high when all TAPS taps hold pixels of the current line.
- fill_count  output  CNT_W  number of current-line pixels in the window, saturating at TAPS.
- line_start_seen  output  1  high while a line start is armed but not yet consumed by a pixel.

Behaviour:
- Reset (rst=1 at an edge): data_out=0, fill_count=0, window_valid=0, line_start_seen=0. Reset overrides en and h_sync in the same cycle.
- Shift: on an edge with en=1, data_out <= {data_in, data_out[DATA_W*TAPS-1:DATA_W]}.
  - Latency: data_in appears in the newest tap on the edge at which it is accepted.
  - en=0: all outputs hold.
- Line-start qualification:
  - first_pix = en & (h_sync | line_start_seen).
  - h_sync=1 with en=0 sets line_start_seen=1.
  - Any accepted pixel (en=1) clears line_start_seen.
  - h_sync=1 together with en=1 makes that pixel first_pix directly; line_start_seen stays 0.
  - Repeated h_sync while already armed has no further effect.
- State machine (two states, encoded by fill_count):
  - FILL (fill_count<TAPS):
    - en & first_pix -> fill_count=1.
    - en & !first_pix -> fill_count+1.
    - Enter FULL when the count reaches TAPS.
  - FULL (fill_count==TAPS):
    - en & !first_pix -> stay, count saturates at TAPS (no wrap).
    - en & first_pix -> FILL with fill_count=1.
- window_valid is registered and equals (next fill_count==TAPS). It changes on the same edge as data_out; no extra pipeline stage.
- Pixels accepted before any h_sync after reset count as the current line; the block does not require h_sync to start.
- Mid-line reset: all state is cleared. The next line starts fresh, with or without h_sync.
- Taps not yet written in the current line: contents are defined by the optional feature. window_valid stays 0 in that case unless replication is enabled.

Optional Feature:
- Macro: PIXEL_WINDOW_BORDER_REPLICATE_EN.
- Defined: on a first_pix edge, all TAPS taps load data_in (left-border replication), fill_count=TAPS and window_valid=1 on that same edge. Later pixels shift normally and valid stays high for the rest of the line.
- Undefined: on a first_pix edge, the newest tap loads data_in, all other taps load 0, fill_count=1, window_valid=0. Valid rises on the TAPS-th pixel of the line.

Test Plan (DATA_W=8, TAPS=5):
- Reset then 5 en pulses with data 0x11,0x22,0x33,0x44,0x55 and no h_sync -> after the 5th edge data_out=0x5544332211, fill_count=5, window_valid=1. After the 4th edge window_valid=0, fill_count=4.
- Continue with en and 0x66 -> data_out=0x6655443322, fill_count stays 5 (saturation), valid stays 1.
- en=0 for 3 cycles with data_in toggling -> data_out, fill_count and window_valid unchanged.
- h_sync=1 with en=0, then 2 idle cycles, then en with 0xA0:
  - line_start_seen=1 until the 0xA0 edge, then 0.
  - Without macro: data_out=0xA000000000, fill_count=1, valid=0.
  - With macro: data_out=0xA0A0A0A0A0, fill_count=5, valid=1.
- Mid-line: 3 pixels 0x01..0x03, then rst=1 together with en=1 and h_sync=1 -> all outputs 0 after the edge. The next 5 pixels 0x10..0x14 give 0x1413121110 with valid=1.
- Back-to-back lines: h_sync with en on pixel 0xB0 while in FULL (macro undefined) -> fill_count=1, valid drops the same edge. 4 more pixels 0xB1..0xB4 -> data_out=0xB4B3B2B1B0, valid=1.
